// File: rtl/sorter_scheduler.sv
// Round-robin scheduler sharing one pipelined bitonic sorter between several
// requesters, with a valid/tag sideband pipeline and a credit-protected output FIFO.

module sorter #(
    parameter  int VALUE_BITS = 8,
    parameter  int DEPTH      = 3,
    parameter  int DIRECTION  = 0,
    localparam int SIZE       = 1 << DEPTH,
    localparam int LATENCY    = DEPTH * (DEPTH + 1) / 2
) (
    input  logic                                i_clk,
    input  logic [SIZE-1:0][VALUE_BITS-1:0]     i_data,
    output logic [SIZE-1:0][VALUE_BITS-1:0]     o_data
);

    logic [SIZE-1:0][VALUE_BITS-1:0] w_bus [LATENCY+1];

    assign w_bus[0] = i_data;
    assign o_data   = w_bus[LATENCY];

    // Stage S merges blocks of 2^gk elements using compare distance 2^J; one register per stage.
    for (genvar gk = 1; gk <= DEPTH; gk++) begin : g_k
        for (genvar gj = 0; gj < gk; gj++) begin : g_j
            localparam int S = gk * (gk - 1) / 2 + gj;
            localparam int J = gk - 1 - gj;
            for (genvar gp = 0; gp < SIZE / 2; gp++) begin : g_p
                localparam int LO  = ((gp >> J) << (J + 1)) | (gp & ((1 << J) - 1));
                localparam int HI  = LO + (1 << J);
                localparam bit ASC = ((((LO >> gk) & 1) == 0) == (DIRECTION == 0));
                logic                  w_swap;
                logic [VALUE_BITS-1:0] r_lo;
                logic [VALUE_BITS-1:0] r_hi;

                assign w_swap = ASC ? (w_bus[S][LO] > w_bus[S][HI])
                                    : (w_bus[S][LO] < w_bus[S][HI]);

                // Compare-exchange register; data path carries no reset.
                always_ff @(posedge i_clk) begin
                    r_lo <= w_swap ? w_bus[S][HI] : w_bus[S][LO];
                    r_hi <= w_swap ? w_bus[S][LO] : w_bus[S][HI];
                end

                assign w_bus[S+1][LO] = r_lo;
                assign w_bus[S+1][HI] = r_hi;
            end
        end
    end

endmodule

module sorter_scheduler #(
    parameter  int VALUE_BITS = 8,
    parameter  int DEPTH      = 3,
    parameter  int DIRECTION  = 0,
    parameter  int NUM_REQ    = 2,
    parameter  int FIFO_DEPTH = 8,
    localparam int SIZE       = 1 << DEPTH,
    localparam int LATENCY    = DEPTH * (DEPTH + 1) / 2,
    localparam int ID_BITS    = $clog2(NUM_REQ),
    localparam int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [NUM_REQ-1:0]                           i_req_valid,
    output logic [NUM_REQ-1:0]                           o_req_ready,
    input  logic [NUM_REQ-1:0][SIZE-1:0][VALUE_BITS-1:0] i_req_data,
    output logic                                         o_out_valid,
    input  logic                                         i_out_ready,
    output logic [SIZE-1:0][VALUE_BITS-1:0]              o_out_data,
    output logic [ID_BITS-1:0]                           o_out_id,
    output logic [CNT_BITS-1:0]                          o_credits_used
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TAG_W    = LATENCY * ID_BITS;

    logic [CNT_BITS-1:0]             r_used;
    logic [ID_BITS-1:0]              r_last;
    logic [LATENCY-1:0]              r_vld;
    logic [TAG_W-1:0]                r_tag;
    logic [PTR_BITS-1:0]             r_wr_ptr;
    logic [PTR_BITS-1:0]             r_rd_ptr;
    logic [CNT_BITS-1:0]             r_count;
    logic [SIZE-1:0][VALUE_BITS-1:0] r_mem_data [FIFO_DEPTH];
    logic [ID_BITS-1:0]              r_mem_id   [FIFO_DEPTH];

    logic                            w_can_issue;
    logic                            w_issue;
    logic                            w_hit;
    logic [ID_BITS-1:0]              w_idx;
    logic [ID_BITS-1:0]              w_gnt;
    logic                            w_pop;
    logic                            w_wr;
    logic [SIZE-1:0][VALUE_BITS-1:0] w_sort_in;
    logic [SIZE-1:0][VALUE_BITS-1:0] w_sort_out;

    // Round-robin search from last+1; the reverse walk lets the nearest hit win.
    always_comb begin
        w_can_issue = !i_rst && (r_used < CNT_BITS'(FIFO_DEPTH));
        w_issue     = 1'b0;
        w_gnt       = '0;
        w_idx       = '0;
        w_hit       = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx   = ID_BITS'((int'(r_last) + off) % NUM_REQ);
            w_hit   = w_can_issue && i_req_valid[w_idx];
            w_gnt   = w_hit ? w_idx : w_gnt;
            w_issue = w_issue | w_hit;
        end
    end

    // One-hot grant back to the selected requester.
    always_comb begin
        o_req_ready = '0;
        if (w_issue) begin
            o_req_ready[w_gnt] = 1'b1;
        end else begin
            o_req_ready = '0;
        end
    end

    assign w_sort_in = w_issue ? i_req_data[w_gnt] : '0;

    sorter #(
        .VALUE_BITS (VALUE_BITS),
        .DEPTH      (DEPTH),
        .DIRECTION  (DIRECTION)
    ) u_sorter (
        .i_clk  (i_clk),
        .i_data (w_sort_in),
        .o_data (w_sort_out)
    );

    assign w_wr        = r_vld[LATENCY-1];
    assign o_out_valid = (r_count != '0);
    assign w_pop       = o_out_valid && i_out_ready;
    assign o_out_data  = o_out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign o_out_id    = o_out_valid ? r_mem_id[r_rd_ptr] : '0;
    assign o_credits_used = r_used;

    // Control state: credits, arbiter pointer, sideband pipeline and FIFO pointers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_used   <= '0;
            r_last   <= '0;
            r_vld    <= '0;
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_used   <= r_used + CNT_BITS'(w_issue) - CNT_BITS'(w_pop);
            r_last   <= w_issue ? w_gnt : r_last;
            r_vld    <= (r_vld << 1) | LATENCY'(w_issue);
            r_tag    <= (r_tag << ID_BITS) | TAG_W'(w_gnt);
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_BITS'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_BITS'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_BITS'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count  <= r_count + CNT_BITS'(w_wr) - CNT_BITS'(w_pop);
        end
    end

    // FIFO storage; credits guarantee a free slot whenever a sorted frame lands.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr] <= w_sort_out;
            r_mem_id[r_wr_ptr]   <= r_tag[TAG_W-1 -: ID_BITS];
        end
    end

endmodule
